// File: rtl/xyolo_ctrl_pkg.sv
// Shared definitions for the xyolo load-control sequencer: FSM encoding,
// window-end token layout and the maxpool group-size decode.
package xyolo_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int TOK_W     = 4;
  localparam int TOK_VLD   = 0;
  localparam int TOK_FIRST = 1;
  localparam int TOK_LAST  = 2;
  localparam int TOK_FIN   = 3;

  function automatic logic [2:0] mp_decode(input logic [1:0] enc);
    case (enc)
      2'd0:    mp_decode = 3'd1;
      2'd1:    mp_decode = 3'd2;
      default: mp_decode = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/xyolo_ctrl_delay.sv
// Fixed-depth shift register with async reset; carries window-end tokens
// from the last operand beat to the result-mux load point.
module xyolo_ctrl_delay #(
  parameter int DEPTH = 7,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sr_p [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sr_p[i] <= '0;
    end else begin
      sr_p[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr_p[i] <= sr_p[i-1];
    end
  end

  assign q = sr_p[DEPTH-1];

endmodule

// File: rtl/xyolo_ctrl_seq.sv
// Load-control sequencer for the xyolo MAC/activation/maxpool datapath.
// Optional maxpool grouping is built when XYOLO_CTRL_MAXPOOL_EN is defined.
module xyolo_ctrl_seq
  import xyolo_ctrl_pkg::*;
#(
  parameter int N_MACS   = 1,
  parameter int N_MACS_W = $clog2(N_MACS) + ($clog2(N_MACS) == 0),
  parameter int CNT_W    = 16,
  parameter int RES_LAT  = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [CNT_W-1:0]    acc_len,
  input  logic [CNT_W-1:0]    n_outputs,
  input  logic [1:0]          mp_len,
  input  logic [N_MACS_W-1:0] nmac_sel,
  input  logic                in_valid,
  output logic                op_en,
  output logic                op_gate,
  output logic                ld_acc,
  output logic                ld_res,
  output logic                ld_mp,
  output logic [N_MACS_W-1:0] ld_nmac,
  output logic                out_valid,
  output logic                done,
  output logic                busy
);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    acc_last, win_last, beat_cnt, win_cnt;
  logic [N_MACS_W-1:0] nmac_r;
  logic                run_acc, win_end, run_end, grp_first, grp_last;
  logic [TOK_W-1:0]    tok_in, tok_out;
  logic                out_valid_r, done_r;

  assign run_acc = run & (state == ST_IDLE);
  assign op_en   = (state == ST_ISSUE) & in_valid;
  assign op_gate = op_en;
  assign ld_acc  = op_en & (beat_cnt == '0);
  assign win_end = op_en & (beat_cnt == acc_last);
  assign run_end = win_end & (win_cnt == win_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (run && n_outputs != '0) state_nxt = ST_ISSUE;
      ST_ISSUE: if (run_end) state_nxt = ST_DRAIN;
      ST_DRAIN: if (done_r) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Config latch and beat/window counters; restarted by an accepted run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_last <= '0;
      win_last <= '0;
      nmac_r   <= '0;
      beat_cnt <= '0;
      win_cnt  <= '0;
    end else if (run_acc) begin
      acc_last <= (acc_len == '0) ? '0 : acc_len - 1'b1;
      win_last <= n_outputs - 1'b1;
      nmac_r   <= nmac_sel;
      beat_cnt <= '0;
      win_cnt  <= '0;
    end else if (op_en) begin
      beat_cnt <= win_end ? '0 : beat_cnt + 1'b1;
      if (win_end) win_cnt <= win_cnt + 1'b1;
    end
  end

`ifdef XYOLO_CTRL_MAXPOOL_EN
  logic [1:0] pool_cnt, mp_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pool_cnt <= '0;
      mp_last  <= '0;
    end else if (run_acc) begin
      pool_cnt <= '0;
      mp_last  <= 2'(mp_decode(mp_len) - 3'd1);
    end else if (win_end) begin
      pool_cnt <= (pool_cnt == mp_last) ? 2'd0 : pool_cnt + 2'd1;
    end
  end

  assign grp_first = (pool_cnt == 2'd0);
  // A run that ends mid-group still has to emit its partial maximum.
  assign grp_last  = (pool_cnt == mp_last) | run_end;
  assign ld_mp     = tok_out[TOK_VLD] & ~tok_out[TOK_FIRST];
`else
  logic mp_len_unused;
  assign mp_len_unused = ^mp_len;
  assign grp_first     = 1'b1;
  assign grp_last      = 1'b1;
  assign ld_mp         = 1'b0;
`endif

  always_comb begin
    tok_in            = '0;
    tok_in[TOK_VLD]   = win_end;
    tok_in[TOK_FIRST] = grp_first;
    tok_in[TOK_LAST]  = grp_last;
    tok_in[TOK_FIN]   = run_end;
  end

  xyolo_ctrl_delay #(
    .DEPTH (RES_LAT),
    .W     (TOK_W)
  ) u_tok_pipe (
    .clk (clk),
    .rst (rst),
    .d   (tok_in),
    .q   (tok_out)
  );

  assign ld_res = tok_out[TOK_VLD];

  // Result stage: one cycle after the result-register load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      out_valid_r <= tok_out[TOK_VLD] & tok_out[TOK_LAST];
      done_r      <= (tok_out[TOK_VLD] & tok_out[TOK_FIN]) |
                     (run_acc & (n_outputs == '0));
    end
  end

  assign out_valid = out_valid_r;
  assign done      = done_r;
  assign busy      = (state != ST_IDLE);
  assign ld_nmac   = nmac_r;

endmodule

// File: tb/tb_xyolo_ctrl_seq.sv
// Directed self-checking bench for xyolo_ctrl_seq (default RES_LAT=7);
// expected cycle masks follow the maxpool build when XYOLO_CTRL_MAXPOOL_EN is set.
module tb_xyolo_ctrl_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [15:0] acc_len = '0;
  logic [15:0] n_outputs = '0;
  logic [1:0]  mp_len = '0;
  logic [0:0]  nmac_sel = '0;
  logic        in_valid = 1'b0;
  logic        op_en, op_gate, ld_acc, ld_res, ld_mp, out_valid, done, busy;
  logic [0:0]  ld_nmac;

  int total = 0;
  int bad   = 0;

  xyolo_ctrl_seq dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .acc_len   (acc_len),
    .n_outputs (n_outputs),
    .mp_len    (mp_len),
    .nmac_sel  (nmac_sel),
    .in_valid  (in_valid),
    .op_en     (op_en),
    .op_gate   (op_gate),
    .ld_acc    (ld_acc),
    .ld_res    (ld_res),
    .ld_mp     (ld_mp),
    .ld_nmac   (ld_nmac),
    .out_valid (out_valid),
    .done      (done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".op_en"},     16'(op_en),     16'h0);
    chk({tag, ".op_gate"},   16'(op_gate),   16'h0);
    chk({tag, ".ld_acc"},    16'(ld_acc),    16'h0);
    chk({tag, ".ld_res"},    16'(ld_res),    16'h0);
    chk({tag, ".ld_mp"},     16'(ld_mp),     16'h0);
    chk({tag, ".ld_nmac"},   16'(ld_nmac),   16'h0);
    chk({tag, ".out_valid"}, 16'(out_valid), 16'h0);
    chk({tag, ".done"},      16'(done),      16'h0);
    chk({tag, ".busy"},      16'(busy),      16'h0);
  endtask

  // One scenario: cycle 0 is the cycle in which the first run is presented.
  // Config inputs change after cycle 0 to prove they are latched.
  task automatic scn(input string tag, input logic [15:0] al, input logic [15:0] no,
                     input logic [1:0] mp, input logic nsel, input logic [31:0] run_m,
                     input logic [31:0] iv_m, input logic [31:0] e_op, input logic [31:0] e_acc,
                     input logic [31:0] e_res, input logic [31:0] e_mp, input logic [31:0] e_ov,
                     input logic [31:0] e_done, input logic [31:0] e_busy, input int ncyc);
    string t;
    for (int k = 0; k < ncyc; k++) begin
      run       = run_m[k];
      in_valid  = iv_m[k];
      acc_len   = (k == 0) ? al : al + 16'd5;
      n_outputs = (k == 0) ? no : no + 16'd3;
      mp_len    = (k == 0) ? mp : ~mp;
      nmac_sel  = (k == 0) ? nsel : ~nsel;
      #1;
      t = $sformatf("%s@%0d", tag, k);
      chk({t, ".op_en"},     16'(op_en),     16'(e_op[k]));
      chk({t, ".op_gate"},   16'(op_gate),   16'(e_op[k]));
      chk({t, ".ld_acc"},    16'(ld_acc),    16'(e_acc[k]));
      chk({t, ".ld_res"},    16'(ld_res),    16'(e_res[k]));
      chk({t, ".ld_mp"},     16'(ld_mp),     16'(e_mp[k]));
      chk({t, ".out_valid"}, 16'(out_valid), 16'(e_ov[k]));
      chk({t, ".done"},      16'(done),      16'(e_done[k]));
      chk({t, ".busy"},      16'(busy),      16'(e_busy[k]));
      if (k >= 1) chk({t, ".ld_nmac"}, 16'(ld_nmac), 16'(nsel));
      @(negedge clk);
    end
    run      = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // acc_len=3, n_outputs=2; extra runs at 5 (busy) and 14 (same cycle as done)
    scn("s1", 16'd3, 16'd2, 2'd0, 1'b1, 32'h0000_4021, 32'hFFFF_FFFF,
        32'h0000_007E, 32'h0000_0012, 32'h0000_2400, 32'h0,
        32'h0000_4800, 32'h0000_4000, 32'h0000_7FFE, 18);

    // acc_len=2, n_outputs=1, stall at cycle 2
    scn("s2", 16'd2, 16'd1, 2'd0, 1'b0, 32'h0000_0001, 32'hFFFF_FFFB,
        32'h0000_000A, 32'h0000_0002, 32'h0000_0400, 32'h0,
        32'h0000_0800, 32'h0000_0800, 32'h0000_0FFE, 15);

    // acc_len=1, n_outputs=4, mp_len=1
`ifdef XYOLO_CTRL_MAXPOOL_EN
    scn("s3", 16'd1, 16'd4, 2'd1, 1'b1, 32'h0000_0001, 32'hFFFF_FFFF,
        32'h0000_001E, 32'h0000_001E, 32'h0000_0F00, 32'h0000_0A00,
        32'h0000_1400, 32'h0000_1000, 32'h0000_1FFE, 16);
`else
    scn("s3", 16'd1, 16'd4, 2'd1, 1'b1, 32'h0000_0001, 32'hFFFF_FFFF,
        32'h0000_001E, 32'h0000_001E, 32'h0000_0F00, 32'h0,
        32'h0000_1E00, 32'h0000_1000, 32'h0000_1FFE, 16);
`endif

    // n_outputs=0: only a done pulse
    scn("s4", 16'd3, 16'd0, 2'd0, 1'b0, 32'h0000_0001, 32'hFFFF_FFFF,
        32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_0002, 32'h0, 6);

    // Reset in cycle 5 of scenario 1
    acc_len   = 16'd3;
    n_outputs = 16'd2;
    nmac_sel  = 1'b1;
    in_valid  = 1'b1;
    run       = 1'b1;
    @(negedge clk);
    run = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all_zero("rst_hi0");
    @(negedge clk);
    #1;
    chk_all_zero("rst_hi1");
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      chk($sformatf("post_rst@%0d.ld_res", k),    16'(ld_res),    16'h0);
      chk($sformatf("post_rst@%0d.out_valid", k), 16'(out_valid), 16'h0);
      chk($sformatf("post_rst@%0d.done", k),      16'(done),      16'h0);
      chk($sformatf("post_rst@%0d.busy", k),      16'(busy),      16'h0);
      @(negedge clk);
    end
    in_valid = 1'b0;

    // Fresh run repeats scenario-1 timing
    scn("s1r", 16'd3, 16'd2, 2'd0, 1'b1, 32'h0000_0001, 32'hFFFF_FFFF,
        32'h0000_007E, 32'h0000_0012, 32'h0000_2400, 32'h0,
        32'h0000_4800, 32'h0000_4000, 32'h0000_7FFE, 18);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xyolo_ctrl_seq.md
# xyolo_ctrl_seq

Sequencer that drives the load-control side of the xyolo MAC/activation/maxpool datapath. It paces operand beats from the feeding memories and asserts `ld_acc` on the first beat of every accumulation window. It delays window-end tokens through a fixed-latency pipe so that `ld_res` and `ld_mp` arrive exactly when the activated result reaches the datapath result mux. It sits between the layer-level controller (which writes the config and pulses `run`) and the xyolo instance(s), and reports completed outputs to the write stage.

## Interface
Parameters:
- `N_MACS`, 1: MAC lanes in the driven datapath.
- `N_MACS_W`, `$clog2(N_MACS)+($clog2(N_MACS)==0)`: lane-select width.
- `CNT_W`, 16: width of the window-length and output-count fields.
- `RES_LAT`, 7: cycles from the last operand beat of a window to the cycle `ld_res` must be high; minimum 1.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: async active-high reset.
- `run` in 1: start pulse; ignored while `busy`.
- `acc_len` in CNT_W: operand beats per window; 0 is treated as 1.
- `n_outputs` in CNT_W: windows per run.
- `mp_len` in 2: maxpool group size, encoded as 0→1, 1→2, 2→4, 3→4.
- `nmac_sel` in N_MACS_W: bypass lane index.
- `in_valid` in 1: operands are presented this cycle.
- `op_en` out 1: beat consumed; the feeder advances its addresses.
- `op_gate` out 1: low forces the weight operand to zero (stall filler).
- `ld_acc` out 1: first beat of a window.
- `ld_res` out 1: result-register load.
- `ld_mp` out 1: compare with the held result (non-first member of a maxpool group).
- `ld_nmac` out N_MACS_W: latched `nmac_sel`.
- `out_valid` out 1: `flow_out` holds a final result.
- `done` out 1: pulse on the last `out_valid` of a run.
- `busy` out 1: a run is in progress.

## Operation
- FSM states:
  - IDLE: on `run` with `n_outputs`≠0, go to ISSUE. On `run` with `n_outputs`=0, pulse `done` next cycle and stay in IDLE.
  - ISSUE: go to DRAIN once all `n_outputs*acc_len` beats are issued.
  - DRAIN: go to IDLE in the cycle after the final `out_valid`.
- Config fields are latched on `run`; later changes to them are ignored until the next run.
- Beats are issued only in ISSUE. A beat is `op_en=op_gate=in_valid`. `ld_acc=op_en & (beat_cnt==0)`.
- Stall mid-window: `in_valid`=0 gives `op_gate`=0, so the MAC accumulates zero. The beat counter holds and the window is not extended in effect.
- Stall at a window boundary: `ld_acc` is deferred to the next valid beat.
- The beat counter wraps to 0 at `acc_len-1`. The window counter increments on that wrap.
- The last beat of a window pushes a token with `grp_first` and `grp_last` flags into a `RES_LAT`-deep shift register. The register shifts every cycle and is never stalled.
- Token at the pipe output gives `ld_res=1` and `ld_mp=!grp_first`.
- `out_valid` is asserted the cycle after `ld_res` when that token had `grp_last`.
- Group membership comes from a pool counter that wraps at the decoded `mp_len`. A run ending mid-group forces `grp_last` on the final window.
- `busy` is high from the cycle after `run` until DRAIN exits.

## Timing
- Reset value of every output is 0, including `ld_nmac`.
- Reset mid-run: everything clears immediately, the pipe is flushed, no `done` is produced.
- `op_en` can first be high in the cycle after `run`.
- Latencies:
  - Last beat at cycle t gives `ld_res` at t+RES_LAT.
  - Final `out_valid` and `done` occur at t+RES_LAT+1.
- A `run` in the same cycle as `done` is ignored, because `busy` is still 1.

## Configuration
- `XYOLO_CTRL_MAXPOOL_EN` defined: `mp_len`, the pool counter and `ld_mp` logic are present.
- Not defined:
  - `mp_len` is ignored and `ld_mp` is tied to 0.
  - Every token is group-first and group-last, so every `ld_res` is followed by `out_valid`.

## Structure
- The shared package `xyolo_ctrl_pkg` holds:
  - FSM state encoding (IDLE, ISSUE, DRAIN).
  - Token bit positions.
  - The `mp_len` decode function.
- One sub-module, `xyolo_ctrl_delay`: a parameterised `RES_LAT`×W shift register with async reset, reused for the token pipe.

## Test plan
- `acc_len`=3, `n_outputs`=2, `in_valid`=1, `run`@0:
  - `op_en` high at cycles 1–6, `ld_acc` at 1 and 4.
  - `ld_res` at 10 and 13, `out_valid` at 11 and 14, `done` at 14, `busy` low at 15.
- `acc_len`=2, `n_outputs`=1, `in_valid`=0 at cycle 2 only:
  - beats at 1 and 3, `op_gate`=0 at cycle 2.
  - `ld_res` at 10, `out_valid` at 11.
- With `XYOLO_CTRL_MAXPOOL_EN`, `acc_len`=1, `n_outputs`=4, `mp_len`=1 (group of 2):
  - `ld_res` at 8–11, `ld_mp` at 9 and 11.
  - `out_valid` only at 10 and 12, `done` at 12.
- Same stimulus without the macro: `ld_mp` never high, `out_valid` at 9–12.
- `run` with `n_outputs`=0: no `op_en`, `done` pulse at cycle 1. A second `run` during `busy` has no effect.
- `rst` asserted at cycle 5 of the first scenario:
  - all outputs read 0 while `rst` is high.
  - no `ld_res`, `out_valid` or `done` afterwards.
  - a fresh `run` then repeats the scenario-1 timing.
